// File: rtl/decodificador_secuencial.sv
// Registered 4-bit code word to 1-of-10 decimal decoder (BCD, Excess-3 or Gray),
// with one output register using valid/ready handshakes and a saturating illegal-word counter.
module decodificador_secuencial #(
  parameter int CODE_SEL = 1,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       d,
  output logic             err,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count
);

  generate
    if (CODE_SEL < 0 || CODE_SEL > 2) begin : g_bad_code_sel
      $error("decodificador_secuencial: CODE_SEL must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_next;
  logic       accept;
  logic       load;
  logic [9:0] dec_d;
  logic       dec_err;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Pure decode of the incoming word; only sampled into the register on accept.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_d   = 10'b0;
    dec_err = 1'b1;
    if (CODE_SEL == 0) begin
      if (code <= 4'd9) begin
        dec_d   = 10'b1 << code;
        dec_err = 1'b0;
      end
    end else if (CODE_SEL == 1) begin
      if (code >= 4'd3 && code <= 4'd12) begin
        dec_d   = 10'b1 << (code - 4'd3);
        dec_err = 1'b0;
      end
    end else begin
      dec_err = 1'b0;
      case (code)
        4'b0000: dec_d = 10'b00_0000_0001;
        4'b0001: dec_d = 10'b00_0000_0010;
        4'b0011: dec_d = 10'b00_0000_0100;
        4'b0010: dec_d = 10'b00_0000_1000;
        4'b0110: dec_d = 10'b00_0001_0000;
        4'b0111: dec_d = 10'b00_0010_0000;
        4'b0101: dec_d = 10'b00_0100_0000;
        4'b0100: dec_d = 10'b00_1000_0000;
        4'b1100: dec_d = 10'b01_0000_0000;
        4'b1101: dec_d = 10'b10_0000_0000;
        default: dec_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_next = FULL;
        load       = 1'b1;
      end
      FULL: if (out_ready) begin
        state_next = accept ? FULL : EMPTY;
        load       = accept;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // When FULL and stalled, load stays low, so d/err are bit-stable and code is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d   <= 10'b0;
      err <= 1'b0;
    end else if (load) begin
      d   <= dec_d;
      err <= dec_err;
    end
  end

  // clr_err wins over a same-cycle illegal accept; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && dec_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
